// File: rtl/tour_cmd_seq_if.sv
// Command bus between the UART wrapper, the tour sequencer and the command
// processor.
//   cmd_UART/cmd_rdy_UART : command from the UART wrapper
//   clr_cmd_rdy           : command processor consumed the current cmd
//   send_resp             : command processor finished the current cmd
//   cmd/cmd_rdy           : command presented to the command processor
//   resp                  : response byte returned to the UART
// master: the sequencer view; slave: the command processor / UART view.
interface tour_cmd_seq_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    modport master (
        input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output cmd, cmd_rdy, resp
    );

    modport slave (
        output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd_seq.sv
// Knight-tour command sequencer and UART command mux.
// After start_tour, walks NUM_MOVES one-hot moves read from the solver at
// mv_indx and issues a vertical move command followed by a horizontal
// fanfare command for each. While idle, UART commands pass straight through.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start_tour  : one-cycle pulse, solver finished
//   move        : one-hot move at mv_indx (combinational from the solver)
//   mv_indx     : move index presented to the solver
//   bus         : command bus (tour_cmd_seq_if.master)
//   tour_done   : one-cycle pulse after the last move completes; present only
//                 when TOUR_CMD_SEQ_DONE_EN is defined
// cmd, cmd_rdy and resp are combinational from state, mv_indx and move.
module tour_cmd_seq #(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    tour_cmd_seq_if.master bus
`ifdef TOUR_CMD_SEQ_DONE_EN
    ,
    output logic        tour_done
`endif
);

    localparam int unsigned IDX_W      = 5;
    localparam logic [3:0]  OP_MOVE    = 4'b0010;
    localparam logic [3:0]  OP_FANFARE = 4'b0011;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    localparam logic [7:0] HDG_NORTH  = 8'h00;
    localparam logic [7:0] HDG_SOUTH  = 8'h7F;
    localparam logic [7:0] HDG_EAST   = 8'hBF;
    localparam logic [7:0] HDG_WEST   = 8'h3F;
    localparam logic [7:0] RESP_IDLE  = 8'hA5;
    localparam logic [7:0] RESP_TOUR  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD_V  = 3'd1,
        WAIT_V = 3'd2,
        CMD_H  = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    state_t     state;
    state_t     nxt_state;
    logic       last_move;
    logic [7:0] hdg_v;
    logic [3:0] sq_v;
    logic [7:0] hdg_h;
    logic [3:0] sq_h;

    assign last_move = (mv_indx == LAST_IDX);

    // Move decode; lowest set bit has priority, no bit set gives null legs.
    always_comb begin
        hdg_v = HDG_NORTH;
        sq_v  = 4'h0;
        hdg_h = HDG_NORTH;
        sq_h  = 4'h0;
        casez (move)
            8'b???????1: begin hdg_v = HDG_NORTH; sq_v = 4'd2; hdg_h = HDG_WEST; sq_h = 4'd1; end
            8'b??????10: begin hdg_v = HDG_NORTH; sq_v = 4'd2; hdg_h = HDG_EAST; sq_h = 4'd1; end
            8'b?????100: begin hdg_v = HDG_NORTH; sq_v = 4'd1; hdg_h = HDG_WEST; sq_h = 4'd2; end
            8'b????1000: begin hdg_v = HDG_SOUTH; sq_v = 4'd1; hdg_h = HDG_WEST; sq_h = 4'd2; end
            8'b???10000: begin hdg_v = HDG_SOUTH; sq_v = 4'd2; hdg_h = HDG_WEST; sq_h = 4'd1; end
            8'b??100000: begin hdg_v = HDG_SOUTH; sq_v = 4'd2; hdg_h = HDG_EAST; sq_h = 4'd1; end
            8'b?1000000: begin hdg_v = HDG_SOUTH; sq_v = 4'd1; hdg_h = HDG_EAST; sq_h = 4'd2; end
            8'b10000000: begin hdg_v = HDG_NORTH; sq_v = 4'd1; hdg_h = HDG_EAST; sq_h = 4'd2; end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // Next-state logic; handshakes outside their own state are ignored.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (start_tour)      nxt_state = CMD_V;
            CMD_V:   if (bus.clr_cmd_rdy) nxt_state = WAIT_V;
            WAIT_V:  if (bus.send_resp)   nxt_state = CMD_H;
            CMD_H:   if (bus.clr_cmd_rdy) nxt_state = WAIT_H;
            WAIT_H:  if (bus.send_resp)   nxt_state = last_move ? IDLE : CMD_V;
            default:                      nxt_state = IDLE;
        endcase
    end

    // Output mux; cmd is held through WAIT_* so it stays stable after consume.
    always_comb begin
        bus.cmd     = bus.cmd_UART;
        bus.cmd_rdy = bus.cmd_rdy_UART;
        bus.resp    = RESP_IDLE;
        case (state)
            CMD_V: begin
                bus.cmd     = {OP_MOVE, hdg_v, sq_v};
                bus.cmd_rdy = 1'b1;
                bus.resp    = RESP_TOUR;
            end
            WAIT_V: begin
                bus.cmd     = {OP_MOVE, hdg_v, sq_v};
                bus.cmd_rdy = 1'b0;
                bus.resp    = RESP_TOUR;
            end
            CMD_H: begin
                bus.cmd     = {OP_FANFARE, hdg_h, sq_h};
                bus.cmd_rdy = 1'b1;
                bus.resp    = RESP_TOUR;
            end
            WAIT_H: begin
                bus.cmd     = {OP_FANFARE, hdg_h, sq_h};
                bus.cmd_rdy = 1'b0;
                // Final acknowledge of the tour reads as idle.
                bus.resp    = last_move ? RESP_IDLE : RESP_TOUR;
            end
            default: ;
        endcase
    end

    // Move index; saturates at the last move because WAIT_H then exits to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mv_indx <= '0;
        end else if (state == IDLE && start_tour) begin
            mv_indx <= '0;
        end else if (state == WAIT_H && bus.send_resp && !last_move) begin
            mv_indx <= mv_indx + IDX_W'(1);
        end
    end

`ifdef TOUR_CMD_SEQ_DONE_EN
    // One-cycle completion pulse on the WAIT_H -> IDLE transition.
    always_ff @(posedge clk) begin
        if (!rst_n) tour_done <= 1'b0;
        else        tour_done <= (state == WAIT_H) && bus.send_resp && last_move;
    end
`endif

endmodule

// File: tb/tb_tour_cmd_seq.sv
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
`ifdef TOUR_CMD_SEQ_DONE_EN
    logic        tour_done;
`endif

    tour_cmd_seq_if bus();

    tour_cmd_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .bus        (bus.master)
`ifdef TOUR_CMD_SEQ_DONE_EN
        ,
        .tour_done  (tour_done)
`endif
    );

    always #5 clk = ~clk;

    // Solver model: move is combinational from mv_indx.
    logic [7:0] tour_tbl [32];
    assign move = tour_tbl[mv_indx];

    // Hand-computed legs per lowest set move bit.
    logic [15:0] v_tbl [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                               16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    logic [15:0] h_tbl [8] = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2,
                               16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

    function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit vert);
        for (int b = 0; b < 8; b++) begin
            if (m[b]) return vert ? v_tbl[b] : h_tbl[b];
        end
        return vert ? 16'h2000 : 16'h3000;
    endfunction

    int errors = 0;
    int checks = 0;
    int rises  = 0;
    int done_hi = 0;
    bit mon_en = 1'b0;
    logic rdy_q = 1'b0;
    logic [15:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every cmd_rdy rise must match the next expected cmd.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.cmd_rdy === 1'b1 && rdy_q !== 1'b1) begin
                rises++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 32'(bus.cmd), 32'hFFFF_FFFF);
                end else begin
                    chk("cmd", 32'(bus.cmd), 32'(exp_q.pop_front()));
                end
            end
`ifdef TOUR_CMD_SEQ_DONE_EN
            if (tour_done === 1'b1) done_hi++;
`endif
        end
        rdy_q = bus.cmd_rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.cmd_rdy !== 1'b1) chk(name, 32'(bus.cmd_rdy), 32'h1);
    endtask

    // Plain consume/complete of one leg.
    task automatic run_leg(input int i, input bit vert);
        wait_rdy("leg_rdy_timeout");
        chk("leg_idx", 32'(mv_indx), 32'(i));
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("leg_wait_rdy", 32'(bus.cmd_rdy), 32'h0);
        chk("leg_wait_resp", 32'(bus.resp), (!vert && i == 23) ? 32'hA5 : 32'h5A);
        tick();
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
    endtask

    initial begin
        automatic logic [7:0] moves [24] = '{
            8'h01, 8'h80, 8'h10, 8'h0C, 8'h00, 8'h02, 8'h04, 8'h08,
            8'h20, 8'h40, 8'h01, 8'h80, 8'h10, 8'h02, 8'h04, 8'h08,
            8'h20, 8'h40, 8'h81, 8'h30, 8'h06, 8'hC0, 8'h03, 8'h18};
        for (int k = 0; k < 32; k++) tour_tbl[k] = 8'h00;
        for (int k = 0; k < 24; k++) tour_tbl[k] = moves[k];

        rst_n            = 1'b0;
        start_tour       = 1'b0;
        bus.cmd_UART     = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy  = 1'b0;
        bus.send_resp    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_resp", 32'(bus.resp), 32'hA5);
        chk("rst_idx", 32'(mv_indx), 32'h0);
        chk("rst_rdy", 32'(bus.cmd_rdy), 32'h0);
        tick();
        mon_en = 1'b1;

        // Idle passthrough.
        exp_q.push_back(16'h4000);
        bus.cmd_UART     = 16'h4000;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("pass_cmd", 32'(bus.cmd), 32'h4000);
        chk("pass_rdy", 32'(bus.cmd_rdy), 32'h1);
        chk("pass_resp", 32'(bus.resp), 32'hA5);
        tick();
        bus.cmd_rdy_UART = 1'b0;
        tick();

        // Full tour with protocol abuse mixed in.
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(exp_cmd(moves[i], 1'b1));
            exp_q.push_back(exp_cmd(moves[i], 1'b0));
        end
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        chk("start_rdy", 32'(bus.cmd_rdy), 32'h1);
        chk("start_idx", 32'(mv_indx), 32'h0);
        // UART activity during the tour must not leak through.
        bus.cmd_UART     = 16'hFFFF;
        bus.cmd_rdy_UART = 1'b1;

        for (int i = 0; i < 24; i++) begin
            if (i == 23) begin
                bus.cmd_UART     = 16'h0BAD;
                bus.cmd_rdy_UART = 1'b0;
            end
            wait_rdy("v_rdy_timeout");
            chk("v_idx", 32'(mv_indx), 32'(i));
            if (i == 0) begin
                bus.send_resp = 1'b1;
                tick();
                bus.send_resp = 1'b0;
                chk("sresp_in_cmdv", 32'(bus.cmd_rdy), 32'h1);
            end
            bus.clr_cmd_rdy = 1'b1;
            tick();
            bus.clr_cmd_rdy = 1'b0;
            chk("waitv_rdy", 32'(bus.cmd_rdy), 32'h0);
            chk("waitv_resp", 32'(bus.resp), 32'h5A);
            if (i == 1) begin
                start_tour = 1'b1;
                tick();
                start_tour = 1'b0;
                chk("start_midtour_idx", 32'(mv_indx), 32'h1);
                chk("start_midtour_rdy", 32'(bus.cmd_rdy), 32'h0);
            end
            if (i == 3) begin
                bus.clr_cmd_rdy = 1'b1;
                tick();
                bus.clr_cmd_rdy = 1'b0;
                chk("clr_in_waitv", 32'(bus.cmd_rdy), 32'h0);
            end
            bus.send_resp = 1'b1;
            tick();
            bus.send_resp = 1'b0;

            wait_rdy("h_rdy_timeout");
            if (i == 2) begin
                bus.clr_cmd_rdy = 1'b1;
                bus.send_resp   = 1'b1;
                tick();
                bus.clr_cmd_rdy = 1'b0;
                bus.send_resp   = 1'b0;
                tick();
                chk("clr_resp_cmdh_rdy", 32'(bus.cmd_rdy), 32'h0);
                chk("clr_resp_cmdh_idx", 32'(mv_indx), 32'h2);
            end else begin
                bus.clr_cmd_rdy = 1'b1;
                tick();
                bus.clr_cmd_rdy = 1'b0;
                chk("waith_rdy", 32'(bus.cmd_rdy), 32'h0);
            end
            chk("waith_resp", 32'(bus.resp), (i == 23) ? 32'hA5 : 32'h5A);
            bus.send_resp = 1'b1;
            tick();
            bus.send_resp = 1'b0;
        end
        chk("end_resp", 32'(bus.resp), 32'hA5);
        chk("end_pass_cmd", 32'(bus.cmd), 32'h0BAD);
        chk("end_pass_rdy", 32'(bus.cmd_rdy), 32'h0);
`ifdef TOUR_CMD_SEQ_DONE_EN
        chk("done_pulse", 32'(tour_done), 32'h1);
`endif
        tick();
`ifdef TOUR_CMD_SEQ_DONE_EN
        chk("done_clear", 32'(tour_done), 32'h0);
`endif
        tick();

        // Second tour, reset mid-tour in WAIT_H at move 10.
        for (int i = 0; i <= 10; i++) begin
            exp_q.push_back(exp_cmd(moves[i], 1'b1));
            exp_q.push_back(exp_cmd(moves[i], 1'b0));
        end
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_leg(i, 1'b1);
            run_leg(i, 1'b0);
        end
        run_leg(10, 1'b1);
        wait_rdy("h10_rdy_timeout");
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("h10_idx", 32'(mv_indx), 32'd10);
        chk("h10_rdy", 32'(bus.cmd_rdy), 32'h0);
        exp_q.push_back(16'h1234);
        bus.cmd_UART     = 16'h1234;
        bus.cmd_rdy_UART = 1'b1;
        rst_n            = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_idx", 32'(mv_indx), 32'h0);
        chk("midrst_resp", 32'(bus.resp), 32'hA5);
        chk("midrst_cmd", 32'(bus.cmd), 32'h1234);
        chk("midrst_rdy", 32'(bus.cmd_rdy), 32'h1);
        tick();
        bus.cmd_rdy_UART = 1'b0;
        tick();
        tick();

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("rise_count", 32'(rises), 32'd72);
`ifdef TOUR_CMD_SEQ_DONE_EN
        chk("done_count", 32'(done_hi), 32'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Downstream consumer of the tour solver. After the solver reports a finished tour, this block walks the 24 stored one-hot knight moves and turns each into two motion commands for the command processor: a vertical leg, then a horizontal leg with fanfare.
- When no tour is running, it passes UART commands through unchanged, so it sits as the command mux in front of the command processor.

Parameters:
- NUM_MOVES, 24, number of moves in a tour (index range 0..NUM_MOVES-1).
- OP_MOVE, 4'b0010, opcode for a plain move.
- OP_FANFARE, 4'b0011, opcode for a move with fanfare.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- start_tour  in  1  one-cycle pulse: solver finished, begin sequencing.
- move  in  8  one-hot move read from the solver at mv_indx.
- mv_indx  out  5  index of the move being read from the solver.
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy  in  1  command processor has consumed the current cmd.
- send_resp  in  1  command processor has finished executing the current cmd.
- cmd  out  16  {opcode[15:12], heading[11:4], squares[3:0]}.
- cmd_rdy  out  1  cmd valid.
- resp  out  8  response byte returned to the UART.

Behaviour:
- Move decode (dx,dy):
  - bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
  - If more than one bit is set, the lowest set bit wins.
  - move==8'h00: both legs use heading 8'h00, squares 4'h0.
- Vertical leg: cmd = {OP_MOVE, hdg, |dy|}; hdg = 8'h00 (north) if dy>0, 8'h7F (south) if dy<0.
- Horizontal leg: cmd = {OP_FANFARE, hdg, |dx|}; hdg = 8'hBF (east) if dx>0, 8'h3F (west) if dx<0.
- FSM states: IDLE, CMD_V, WAIT_V, CMD_H, WAIT_H. Reset state is IDLE.
  - IDLE: start_tour -> mv_indx<=0, go to CMD_V.
  - CMD_V: cmd_rdy=1 with the vertical cmd. clr_cmd_rdy -> WAIT_V.
  - WAIT_V: cmd_rdy=0. send_resp -> CMD_H.
  - CMD_H: cmd_rdy=1 with the horizontal cmd. clr_cmd_rdy -> WAIT_H.
  - WAIT_H: send_resp and mv_indx==NUM_MOVES-1 -> IDLE. send_resp otherwise -> mv_indx<=mv_indx+1, go to CMD_V.
- Output mux:
  - In IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
  - Outside IDLE: cmd/cmd_rdy come from the FSM, and UART inputs are ignored.
- resp:
  - 8'h5A while touring.
  - 8'hA5 in IDLE, and in WAIT_H while mv_indx==NUM_MOVES-1, so the final acknowledge reads A5.
- Output timing: cmd and cmd_rdy are combinational from state, mv_indx and move. The first tour cmd_rdy is high in the cycle after start_tour.
- move must be stable for at least one cycle after mv_indx changes; the solver's move output is combinational from its indx input, so this holds.
- Boundary rules:
  - start_tour outside IDLE is ignored.
  - send_resp in CMD_V/CMD_H is ignored, including when it arrives together with clr_cmd_rdy.
  - clr_cmd_rdy in WAIT_* states is ignored.
  - mv_indx never exceeds NUM_MOVES-1.
- Reset (rst_n=0 at a clock edge, at any point including mid-tour): state=IDLE, mv_indx=0. Outputs immediately follow the IDLE mux (resp=8'hA5, cmd=cmd_UART).
- Total commands per tour: 2*NUM_MOVES = 48.

Optional Feature:
- Macro: TOUR_CMD_SEQ_DONE_EN.
- Defined: adds output port tour_done (1 bit), reset 0. It pulses high for exactly one cycle on the WAIT_H->IDLE transition after the last move.
- Undefined: the port is absent; no other behaviour changes.

Test Plan:
- Idle passthrough: cmd_UART=16'h4000, cmd_rdy_UART=1 -> cmd=16'h4000, cmd_rdy=1, resp=8'hA5. Pulse start_tour -> next cycle cmd_rdy=1, mv_indx=0.
- move=8'h01: vertical cmd=16'h2002, then after clr_cmd_rdy/send_resp, horizontal cmd=16'h33F1. move=8'h80: cmd=16'h2001, then 16'h3BF2.
- move=8'h10: cmd=16'h27F2, then 16'h33F1. Check resp=8'h5A between legs and cmd_rdy=0 in WAIT states.
- Full tour with a 24-entry move model: exactly 48 cmd_rdy rises; mv_indx goes 0..23; final resp=8'hA5; return to IDLE. With TOUR_CMD_SEQ_DONE_EN, tour_done is a single-cycle pulse.
- Protocol abuse: send_resp in CMD_V (no advance); start_tour mid-tour (ignored); clr_cmd_rdy+send_resp together in CMD_H (moves to WAIT_H only).
- rst_n=0 during WAIT_H at mv_indx=10 -> next edge IDLE, mv_indx=0, resp=8'hA5, UART passthrough restored.
